// File: rtl/anton_neopixel_stream_sequencer_if.sv
// rtl/anton_neopixel_stream_sequencer_if.sv - control, stream-controller and buffer-address bundle
// master is the sequencer side; slave is the register block / stream controller side.
interface anton_neopixel_stream_sequencer_if #(
    parameter int PIXELS_BITS = 8
);
    logic                   reg_ctrl_init;
    logic                   reg_ctrl_run;
    logic                   reg_ctrl_loop;
    logic                   reg_ctrl_32bit;
    logic [PIXELS_BITS-1:0] reg_max_pixel;
    logic                   stream_pattern_of;
    logic                   state;
    logic [4:0]             pixel_bit_index;
    logic [PIXELS_BITS-1:0] pixel_index;
    logic [PIXELS_BITS+1:0] buffer_byte_addr;
    logic [2:0]             byte_bit_sel;
    logic                   frame_done;
    logic                   run_clear;

    modport master (
        input  reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_32bit, reg_max_pixel,
        input  stream_pattern_of,
        output state, pixel_bit_index, pixel_index, buffer_byte_addr, byte_bit_sel,
        output frame_done, run_clear
    );

    modport slave (
        output reg_ctrl_init, reg_ctrl_run, reg_ctrl_loop, reg_ctrl_32bit, reg_max_pixel,
        output stream_pattern_of,
        input  state, pixel_bit_index, pixel_index, buffer_byte_addr, byte_bit_sel,
        input  frame_done, run_clear
    );
endinterface

// File: rtl/anton_neopixel_stream_sequencer.sv
// rtl/anton_neopixel_stream_sequencer.sv - NeoPixel frame sequencer: bit/pixel counters, latch gap, buffer addressing
// state encoding: 0 = TRANSMIT, 1 = RESET (latch gap).
module anton_neopixel_stream_sequencer #(
    parameter int PIXELS_BITS = 8,
    parameter int RESET_DELAY = 400
) (
    input  logic clk7mhz,
    input  logic rst_n,
    anton_neopixel_stream_sequencer_if.master seq
);
    typedef enum logic {
        ST_TRANSMIT = 1'b0,
        ST_RESET    = 1'b1
    } state_t;

    localparam logic [11:0]            RESET_LAST = 12'(RESET_DELAY - 1);
    localparam logic [11:0]            CNT_ONE    = 12'd1;
    localparam logic [4:0]             BIT_LAST   = 5'd23;
    localparam logic [4:0]             BIT_ONE    = 5'd1;
    localparam logic [PIXELS_BITS-1:0] PIX_ONE    = PIXELS_BITS'(1);

    state_t                 state_q, state_d;
    logic [4:0]             bit_q, bit_d;
    logic [PIXELS_BITS-1:0] pix_q, pix_d;
    logic [11:0]            cnt_q, cnt_d;
    logic                   fd_q, fd_d;
    logic                   rc_q, rc_d;

    always_ff @(posedge clk7mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RESET;
            bit_q   <= '0;
            pix_q   <= '0;
            cnt_q   <= '0;
            fd_q    <= 1'b0;
            rc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            cnt_q   <= cnt_d;
            fd_q    <= fd_d;
            rc_q    <= rc_d;
        end
    end

    // init wins over everything; with run low every register simply holds.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        pix_d   = pix_q;
        cnt_d   = cnt_q;
        fd_d    = 1'b0;
        rc_d    = 1'b0;
        if (seq.reg_ctrl_init) begin
            state_d = ST_RESET;
            bit_d   = '0;
            pix_d   = '0;
            cnt_d   = '0;
        end else if (seq.reg_ctrl_run) begin
            case (state_q)
                ST_TRANSMIT: begin
                    if (seq.stream_pattern_of) begin
                        if (bit_q != BIT_LAST) begin
                            bit_d = bit_q + BIT_ONE;
                        end else begin
                            bit_d = '0;
                            // >= so a max_pixel lowered below the current pixel still ends the frame
                            if (pix_q >= seq.reg_max_pixel) begin
                                pix_d   = '0;
                                state_d = ST_RESET;
                                cnt_d   = '0;
                            end else begin
                                pix_d = pix_q + PIX_ONE;
                            end
                        end
                    end
                end
                ST_RESET: begin
                    if (cnt_q == RESET_LAST) begin
                        state_d = ST_TRANSMIT;
                        cnt_d   = '0;
                        fd_d    = 1'b1;
                        rc_d    = ~seq.reg_ctrl_loop;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = ST_RESET;
            endcase
        end
    end

    logic [PIXELS_BITS+1:0] pix_ext;
    logic [PIXELS_BITS+1:0] byte_in_pixel;
    logic [PIXELS_BITS+1:0] addr24;

    // pixel*3 built as (pixel<<1)+pixel in the widened domain so it cannot overflow
    always_comb begin
        pix_ext       = {2'b00, pix_q};
        byte_in_pixel = {{PIXELS_BITS{1'b0}}, bit_q[4:3]};
        addr24        = (pix_ext << 1) + pix_ext + byte_in_pixel;
    end

    assign seq.state            = state_q;
    assign seq.pixel_bit_index  = bit_q;
    assign seq.pixel_index      = pix_q;
    assign seq.buffer_byte_addr = seq.reg_ctrl_32bit ? {pix_q, bit_q[4:3]} : addr24;
    assign seq.byte_bit_sel     = 3'd7 - bit_q[2:0];
    assign seq.frame_done       = fd_q;
    assign seq.run_clear        = rc_q;
endmodule

// File: doc/anton_neopixel_stream_sequencer.md
Name: anton_neopixel_stream_sequencer

Overview:
- Sequences the NeoPixel stream datapath at 7 MHz.
- Owns the TRANSMIT/RESET state, the per-pixel bit index (0-23) and the pixel counter.
- Times the latch/reset gap and generates the buffer byte address and bit select for the pixel currently being shifted out.
- Consumes the sub-bit pattern overflow pulse from the stream controller and feeds `state` and `pixel_bit_index` back to it.

Parameters:
- PIXELS_BITS, 8, width of pixel_index and reg_max_pixel.
- RESET_DELAY, 400, clk7mhz cycles spent in RESET (must be >= 350, i.e. 50 us); range 2..4095.

Ports:
- clk7mhz, input, 1, sole clock.
- rst_n, input, 1, asynchronous active-low reset.
- reg_ctrl_init, input, 1, synchronous restart request; highest priority.
- reg_ctrl_run, input, 1, enable; when 0 all counters hold.
- reg_ctrl_loop, input, 1, 1 = start the next frame automatically after RESET.
- reg_ctrl_32bit, input, 1, buffer layout: 1 = 4 bytes/pixel, 0 = 3 bytes/pixel.
- reg_max_pixel, input, PIXELS_BITS, index of the last pixel in the frame.
- stream_pattern_of, input, 1, one-cycle pulse at the end of each streamed bit (last sub-bit step).
- state, output, 1, `ENUM_STATE_TRANSMIT / `ENUM_STATE_RESET.
- pixel_bit_index, output, 5, bit of the current pixel, 0..23.
- pixel_index, output, PIXELS_BITS, current pixel.
- buffer_byte_addr, output, PIXELS_BITS+2, byte address into the pixel buffer.
- byte_bit_sel, output, 3, bit within the byte, MSB first.
- frame_done, output, 1, one-cycle pulse at the end of RESET.
- run_clear, output, 1, one-cycle pulse requesting that reg_ctrl_run be cleared (non-loop mode).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state = RESET, pixel_bit_index = 0, pixel_index = 0, reset_cnt = 0.
  - frame_done = 0, run_clear = 0.
- active = reg_ctrl_run && !reg_ctrl_init.
- init priority: reg_ctrl_init=1 in any cycle → next edge: pixel_bit_index = 0, pixel_index = 0, reset_cnt = 0, state = RESET, no pulses. This overrides any simultaneous stream_pattern_of.
- !active with init=0: all registers hold and pulses stay 0. A frame resumes exactly where it paused.
- TRANSMIT, active, stream_pattern_of=1:
  - pixel_bit_index != 23 → pixel_bit_index+1.
  - pixel_bit_index == 23 → pixel_bit_index = 0, then:
    - pixel_index >= reg_max_pixel → pixel_index = 0, state = RESET, reset_cnt = 0. The >= compare tolerates reg_max_pixel being lowered mid-frame.
    - otherwise → pixel_index+1.
- TRANSMIT, stream_pattern_of=0: hold. stream_pattern_of arriving while in RESET is ignored.
- RESET, active:
  - reset_cnt increments each cycle (12-bit counter).
  - When reset_cnt == RESET_DELAY-1: next edge state = TRANSMIT, reset_cnt = 0, and frame_done is registered high for one cycle.
  - Same condition with reg_ctrl_loop=0: run_clear is registered high for one cycle, concurrent with frame_done.
  - The TRANSMIT entry still happens, but the stream controller stays idle once run drops.
  - reset_cnt wraps only at RESET_DELAY-1; it never overflows.
- RESET is entered at power-up, so a full latch gap always precedes the first frame.
- buffer_byte_addr (combinational from registers):
  - 32bit=1: {pixel_index, pixel_bit_index[4:3]}.
  - 32bit=0: pixel_index*3 + pixel_bit_index[4:3], zero-extended, computed without overflow.
- byte_bit_sel = 7 - pixel_bit_index[2:0], i.e. bit 7 is sent first.
- Latency: each index update is visible one cycle after the stream_pattern_of edge. Outputs carry no combinational path from stream_pattern_of.
- Changing reg_ctrl_32bit mid-frame only changes the addressing; the sequence itself is unaffected.

Test Plan:
- Async reset: release rst_n with run=1, loop=0, RESET_DELAY=400 → exactly 400 cycles in RESET, then frame_done and run_clear each pulse for 1 cycle, state = TRANSMIT.
- Frame, max_pixel=2, pattern_of every 8 cycles → bit index 0..23 three times, pixel 0→1→2→0, RESET entered after the 72nd pulse; addr sequence 0,1,2,3..8 (24-bit mode).
- 32bit=1, pixel 5 bit 17 → buffer_byte_addr = 22, byte_bit_sel = 6; 32bit=0 → addr = 17.
- Pause: drop run at pixel 1 bit 10 for 50 cycles with pattern_of pulsing → indices frozen; resume continues at bit 11.
- init together with pattern_of at pixel 2 bit 23 → next cycle all indices 0, state = RESET, no frame_done.
- Loop=1: two consecutive frames → frame_done pulses twice, run_clear never asserts. Lowering max_pixel from 5 to 1 while at pixel 3 → RESET entered after pixel 3.
